// File: rtl/inc_dec_reg_unit.sv
// Register-file increment/decrement engine: INR/DCR/LOAD/CLR on NUM_REGS registers,
// three-cycle IDLE/EXEC/WB sequence with Z/N/C flags and a retirement pulse.
module inc_dec_reg_unit #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REGS   = 4,
   parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_valid_i,
   output logic                  op_ready_o,
   input  logic [1:0]            op_code_i,
   input  logic [REG_ADDR_W-1:0] op_reg_i,
   input  logic [DATA_WIDTH-1:0] op_data_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  flag_zero_o,
   output logic                  flag_negative_o,
   output logic                  flag_carry_o,
   output logic                  instr_complete_o
);

   localparam int unsigned IDX_W = REG_ADDR_W + 1;

   localparam logic [1:0] OP_INR  = 2'b00;
   localparam logic [1:0] OP_DCR  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Index range check; only matters when NUM_REGS is not a power of two.
   function automatic logic idx_ok(input logic [REG_ADDR_W-1:0] idx);
      return {1'b0, idx} < IDX_W'(NUM_REGS);
   endfunction

   state_t                state;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [1:0]            code_q;
   logic [REG_ADDR_W-1:0] reg_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  carry_q;
   logic                  tgt_ok;
   logic [DATA_WIDTH-1:0] tgt_val;
   logic [DATA_WIDTH-1:0] exec_res;
   logic                  exec_carry;

   assign op_ready_o = (state == ST_IDLE);
   assign tgt_ok     = idx_ok(reg_q);

   // Read port sees the pre-write value until the WB edge.
   always_comb begin
      rd_data_o = '0;
      if (idx_ok(rd_addr_i)) begin
         rd_data_o = regs[rd_addr_i];
      end
   end

   // EXEC-stage result and carry/borrow for the latched op.
   always_comb begin
      tgt_val    = '0;
      exec_res   = '0;
      exec_carry = 1'b0;
      if (tgt_ok) begin
         tgt_val = regs[reg_q];
         case (code_q)
            OP_INR: begin
               exec_res   = tgt_val + DATA_WIDTH'(1);
               exec_carry = &tgt_val;
            end
            OP_DCR: begin
               exec_res   = tgt_val - DATA_WIDTH'(1);
               exec_carry = ~|tgt_val;
            end
            OP_LOAD: exec_res = data_q;
            default: exec_res = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
         code_q           <= '0;
         reg_q            <= '0;
         data_q           <= '0;
         carry_q          <= 1'b0;
         result_o         <= '0;
         flag_zero_o      <= 1'b0;
         flag_negative_o  <= 1'b0;
         flag_carry_o     <= 1'b0;
         instr_complete_o <= 1'b0;
      end else begin
         instr_complete_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_valid_i) begin
                  code_q <= op_code_i;
                  reg_q  <= op_reg_i;
                  data_q <= op_data_i;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               result_o <= exec_res;
               carry_q  <= exec_carry;
               state    <= ST_WB;
            end
            ST_WB: begin
               // Out-of-range targets retire without touching registers or flags.
               if (tgt_ok) begin
                  regs[reg_q]     <= result_o;
                  flag_zero_o     <= (result_o == '0);
                  flag_negative_o <= result_o[DATA_WIDTH-1];
                  flag_carry_o    <= carry_q;
               end
               instr_complete_o <= 1'b1;
               state            <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inc_dec_reg_unit.sv
// Self-checking bench for inc_dec_reg_unit: transaction-level reference model compared
// every cycle, directed scenarios pinned with literal values, then randomized traffic.
module tb_inc_dec_reg_unit;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 4;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid_i;
   logic          op_ready_o;
   logic [1:0]    op_code_i;
   logic [AW-1:0] op_reg_i;
   logic [DW-1:0] op_data_i;
   logic [AW-1:0] rd_addr_i;
   logic [DW-1:0] rd_data_o;
   logic [DW-1:0] result_o;
   logic          flag_zero_o;
   logic          flag_negative_o;
   logic          flag_carry_o;
   logic          instr_complete_o;

   inc_dec_reg_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk              (clk),
      .reset            (reset),
      .op_valid_i       (op_valid_i),
      .op_ready_o       (op_ready_o),
      .op_code_i        (op_code_i),
      .op_reg_i         (op_reg_i),
      .op_data_i        (op_data_i),
      .rd_addr_i        (rd_addr_i),
      .rd_data_o        (rd_data_o),
      .result_o         (result_o),
      .flag_zero_o      (flag_zero_o),
      .flag_negative_o  (flag_negative_o),
      .flag_carry_o     (flag_carry_o),
      .instr_complete_o (instr_complete_o)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state plus one in-flight op with timestamps.
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_res;
   logic          m_z, m_n, m_c, m_cpl;
   logic          pend;
   int            p_acc;
   logic [AW-1:0] p_reg;
   logic [DW-1:0] p_nv;
   logic          p_z, p_n, p_c;
   int            cyc = 0;
   int            free_cyc = 0;
   logic          acc_now;
   int            n_acc = 0;
   int            cpl_seen = 0;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
      m_res = '0; m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_cpl = 1'b0;
      pend = 1'b0; free_cyc = 0; acc_now = 1'b0;
   endtask

   // Applied at each rising edge using the inputs that were stable before it.
   task automatic model_edge();
      logic [DW:0] wide;
      cyc++;
      acc_now = 1'b0;
      m_cpl   = 1'b0;
      if (reset) begin
         model_clear();
         return;
      end
      if (pend && cyc == p_acc + 1) m_res = p_nv;
      if (pend && cyc == p_acc + 2) begin
         m_regs[p_reg] = p_nv;
         m_z = p_z; m_n = p_n; m_c = p_c;
         m_cpl = 1'b1;
         pend  = 1'b0;
      end
      if (op_valid_i && cyc >= free_cyc) begin
         case (op_code_i)
            2'b00:   wide = {1'b0, m_regs[op_reg_i]} + 9'd1;
            2'b01:   wide = {1'b0, m_regs[op_reg_i]} - 9'd1;
            2'b10:   wide = {1'b0, op_data_i};
            default: wide = '0;
         endcase
         p_nv = wide[DW-1:0];
         p_c  = wide[DW];
         p_z  = (p_nv == '0);
         p_n  = p_nv[DW-1];
         p_reg = op_reg_i;
         p_acc = cyc;
         pend  = 1'b1;
         free_cyc = cyc + 3;
         acc_now  = 1'b1;
         n_acc++;
      end
   endtask

   task automatic compare_all();
      if (instr_complete_o) cpl_seen++;
      chk("ready",    32'(op_ready_o),       32'(cyc + 1 >= free_cyc));
      chk("result",   32'(result_o),         32'(m_res));
      chk("zero",     32'(flag_zero_o),      32'(m_z));
      chk("negative", 32'(flag_negative_o),  32'(m_n));
      chk("carry",    32'(flag_carry_o),     32'(m_c));
      chk("complete", 32'(instr_complete_o), 32'(m_cpl));
      chk("rd_data",  32'(rd_data_o),        32'(m_regs[rd_addr_i]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic accept_op(input logic [1:0] code, input logic [AW-1:0] r, input logic [DW-1:0] d);
      int guard = 0;
      op_valid_i = 1'b1; op_code_i = code; op_reg_i = r; op_data_i = d;
      cycle();
      while (!acc_now && guard < 20) begin
         cycle();
         guard++;
      end
      if (!acc_now) chk("accept_timeout", 32'(0), 32'(1));
      op_valid_i = 1'b0;
      op_code_i  = 2'($urandom());
      op_reg_i   = AW'($urandom());
      op_data_i  = DW'($urandom());
   endtask

   task automatic op_full(input logic [1:0] code, input logic [AW-1:0] r, input logic [DW-1:0] d);
      accept_op(code, r, d);
      cycle();
      cycle();
   endtask

   task automatic peek(input string name, input logic [AW-1:0] r, input logic [DW-1:0] exp);
      rd_addr_i = r;
      #1;
      chk(name, 32'(rd_data_o), 32'(exp));
   endtask

   int acc_cyc [4];

   initial begin
      reset = 1'b1; op_valid_i = 1'b0; op_code_i = '0; op_reg_i = '0;
      op_data_i = '0; rd_addr_i = '0;
      model_clear();
      cycle(); cycle();
      reset = 1'b0;
      cycle();
      chk("rst_ready",  32'(op_ready_o),       32'(1));
      chk("rst_result", 32'(result_o),         32'(0));
      chk("rst_flags",  32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(0));
      chk("rst_cpl",    32'(instr_complete_o), 32'(0));

      // INR r1 twice, with pulse timing
      rd_addr_i = 2'd1;
      accept_op(2'b00, 2'd1, 8'h00);
      chk("t1_ready_exec", 32'(op_ready_o), 32'(0));
      chk("t1_cpl_k",      32'(instr_complete_o), 32'(0));
      cycle();
      chk("t1_result_k1", 32'(result_o), 32'(8'h01));
      chk("t1_old_rd_k1", 32'(rd_data_o), 32'(8'h00));
      chk("t1_cpl_k1",    32'(instr_complete_o), 32'(0));
      cycle();
      chk("t1_cpl_k2", 32'(instr_complete_o), 32'(1));
      chk("t1_r1_01",  32'(rd_data_o), 32'(8'h01));
      op_full(2'b00, 2'd1, 8'h00);
      chk("t1_r1_02",  32'(rd_data_o), 32'(8'h02));
      chk("t1_flags",  32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(3'b000));

      // LOAD 7F then INR -> 80, negative
      op_full(2'b10, 2'd1, 8'h7F);
      op_full(2'b00, 2'd1, 8'h00);
      peek("t2_r1_80", 2'd1, 8'h80);
      chk("t2_flags", 32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(3'b010));
      peek("t2_r0", 2'd0, 8'h00);
      peek("t2_r2", 2'd2, 8'h00);
      peek("t2_r3", 2'd3, 8'h00);

      // Wrap both directions on r2
      op_full(2'b10, 2'd2, 8'hFF);
      op_full(2'b00, 2'd2, 8'h00);
      peek("t3_inr_wrap", 2'd2, 8'h00);
      chk("t3_inr_flags", 32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(3'b101));
      op_full(2'b01, 2'd2, 8'h00);
      peek("t3_dcr_wrap", 2'd2, 8'hFF);
      chk("t3_dcr_flags", 32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(3'b011));

      // CLR r3: read port keeps old value until the WB edge
      op_full(2'b10, 2'd3, 8'h5A);
      rd_addr_i = 2'd3;
      accept_op(2'b11, 2'd3, 8'h00);
      rd_addr_i = 2'd3;
      chk("t4_rd_k", 32'(rd_data_o), 32'(8'h5A));
      cycle();
      chk("t4_rd_k1", 32'(rd_data_o), 32'(8'h5A));
      cycle();
      chk("t4_rd_k2", 32'(rd_data_o), 32'(8'h00));
      chk("t4_flags", 32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(3'b100));

      // Back-to-back with valid held high
      cpl_seen = 0;
      for (int i = 0; i < 4; i++) begin
         int guard = 0;
         op_valid_i = 1'b1;
         op_code_i  = 2'($urandom());
         op_reg_i   = AW'($urandom());
         op_data_i  = DW'($urandom());
         cycle();
         while (!acc_now && guard < 20) begin
            cycle();
            guard++;
         end
         if (!acc_now) chk("t5_accept_timeout", 32'(0), 32'(1));
         acc_cyc[i] = cyc;
         chk("t5_ready_low", 32'(op_ready_o), 32'(0));
      end
      op_valid_i = 1'b0;
      repeat (6) cycle();
      for (int i = 1; i < 4; i++) chk("t5_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(3));
      chk("t5_pulses", 32'(cpl_seen), 32'(4));

      // Reset during EXEC aborts the op
      op_full(2'b10, 2'd0, 8'h33);
      op_full(2'b10, 2'd2, 8'h44);
      cpl_seen = 0;
      accept_op(2'b00, 2'd0, 8'h00);
      reset = 1'b1;
      model_clear();
      cycle(); cycle();
      reset = 1'b0;
      cycle(); cycle();
      chk("t6_pulses", 32'(cpl_seen), 32'(0));
      chk("t6_ready",  32'(op_ready_o), 32'(1));
      chk("t6_flags",  32'({flag_zero_o, flag_negative_o, flag_carry_o}), 32'(0));
      peek("t6_r0", 2'd0, 8'h00);
      peek("t6_r2", 2'd2, 8'h00);

      // Randomized traffic with occasional resets
      repeat (400) begin
         op_valid_i = 1'($urandom_range(0, 1));
         op_code_i  = 2'($urandom());
         op_reg_i   = AW'($urandom());
         op_data_i  = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom());
         rd_addr_i  = AW'($urandom());
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            model_clear();
         end else begin
            reset = 1'b0;
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
